// File: rtl/picomips_param.sv
// rtl/picomips_param.sv - parameterised four-state accumulator micro-core
//
// Ports:
//   Clock      sole clock, rising edge
//   Reset      asynchronous active-high reset
//   InstrAddr  program memory address (always the PC)
//   Instr      synchronous ROM data, valid one cycle after InstrAddr
//              {opcode[2:0], rd[RA_W-1:0], imm[DATA_W-1:0]}
//   InData     signed input operand for IN
//   InValid    InData valid
//   InReady    core is waiting in EXEC of an IN and accepts InData
//   Acc        signed accumulator
//   OutStrobe  one-cycle pulse in the NEXT cycle after every Acc write
module picomips_param #(
    parameter int DATA_W   = 8,
    parameter int NREGS    = 4,
    parameter int PC_W     = 5,
    parameter int SATURATE = 0,
    localparam int RA_W    = $clog2(NREGS),
    localparam int IW      = 3 + RA_W + DATA_W
) (
    input  logic              Clock,
    input  logic              Reset,
    output logic [PC_W-1:0]   InstrAddr,
    input  logic [IW-1:0]     Instr,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    output logic [DATA_W-1:0] Acc,
    output logic              OutStrobe
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        NEXT   = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LDI  = 3'b001;
    localparam logic [2:0] OP_ADDI = 3'b010;
    localparam logic [2:0] OP_MULI = 3'b011;
    localparam logic [2:0] OP_ADDR = 3'b100;
    localparam logic [2:0] OP_STR  = 3'b101;
    localparam logic [2:0] OP_IN   = 3'b110;
    localparam logic [2:0] OP_JMP  = 3'b111;

    localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MAX_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    state_t            state;
    state_t            state_n;
    logic [IW-1:0]     ir;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] regs [NREGS];

    logic [2:0]        op;
    logic [RA_W-1:0]   rd;
    logic [DATA_W-1:0] imm;

    assign op  = ir[IW-1 -: 3];
    assign rd  = ir[DATA_W +: RA_W];
    assign imm = ir[DATA_W-1:0];

    assign InstrAddr = pc;
    assign Acc       = acc;

    // Shared adder for ADDI and ADDR. One guard bit: the sum overflowed
    // exactly when the guard bit and the result sign disagree, and the
    // guard bit then carries the true sign of the result.
    logic [DATA_W-1:0] add_b;
    logic [DATA_W:0]   add_sum;
    logic [DATA_W-1:0] add_res;

    assign add_b   = (op == OP_ADDR) ? regs[rd] : imm;
    assign add_sum = {acc[DATA_W-1], acc} + {add_b[DATA_W-1], add_b};

    always_comb begin
        add_res = add_sum[DATA_W-1:0];
        if (SATURATE != 0 && (add_sum[DATA_W] != add_sum[DATA_W-1])) begin
            add_res = add_sum[DATA_W] ? MAX_NEG : MAX_POS;
        end
    end

    // Fixed-point multiply: full signed product, arithmetic shift right
    // by DATA_W-1, low DATA_W bits kept (wraps, never saturates).
    logic signed [2*DATA_W-1:0] mul_a;
    logic signed [2*DATA_W-1:0] mul_b;
    logic signed [2*DATA_W-1:0] mul_p;
    logic [DATA_W-1:0]          mul_res;

    assign mul_a   = {{DATA_W{acc[DATA_W-1]}}, acc};
    assign mul_b   = {{DATA_W{imm[DATA_W-1]}}, imm};
    assign mul_p   = mul_a * mul_b;
    assign mul_res = mul_p[2*DATA_W-2 -: DATA_W];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        InReady   = 1'b0;
        OutStrobe = 1'b0;
        case (state)
            FETCH:  state_n = DECODE;
            DECODE: state_n = EXEC;
            EXEC: begin
                if (op == OP_IN) begin
                    InReady = 1'b1;
                    if (InValid) begin
                        state_n = NEXT;
                    end
                end else begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                state_n   = FETCH;
                OutStrobe = (op == OP_LDI) || (op == OP_ADDI) || (op == OP_MULI) ||
                            (op == OP_ADDR) || (op == OP_IN);
            end
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ir  <= '0;
            pc  <= '0;
            acc <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                DECODE: ir <= Instr;
                EXEC: begin
                    case (op)
                        OP_LDI:  acc <= imm;
                        OP_ADDI: acc <= add_res;
                        OP_MULI: acc <= mul_res;
                        OP_ADDR: acc <= add_res;
                        OP_STR:  regs[rd] <= acc;
                        OP_IN: begin
                            if (InValid) begin
                                acc <= InData;
                            end
                        end
                        default: ;
                    endcase
                end
                NEXT: begin
                    if (op == OP_JMP) begin
                        pc <= imm[PC_W-1:0];
                    end else begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_picomips_param.sv
// tb/tb_picomips_param.sv - self-checking bench for picomips_param (wrapping and saturating builds)
module tb_picomips_param;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int PW = 5;
    localparam int RW = 2;
    localparam int IW = 3 + RW + DW;
    localparam int DEPTH = 1 << PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;

    logic [PW-1:0] addr_w, addr_s;
    logic [IW-1:0] instr_w = '0, instr_s = '0;
    logic          ready_w, ready_s;
    logic [DW-1:0] acc_w, acc_s;
    logic          strobe_w, strobe_s;

    logic [IW-1:0] rom [DEPTH];

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        instr_w <= rom[addr_w];
        instr_s <= rom[addr_s];
    end

    picomips_param #(.DATA_W(DW), .NREGS(NR), .PC_W(PW), .SATURATE(0)) u_wrap (
        .Clock(clk), .Reset(rst), .InstrAddr(addr_w), .Instr(instr_w),
        .InData(in_data), .InValid(in_valid), .InReady(ready_w),
        .Acc(acc_w), .OutStrobe(strobe_w)
    );

    picomips_param #(.DATA_W(DW), .NREGS(NR), .PC_W(PW), .SATURATE(1)) u_sat (
        .Clock(clk), .Reset(rst), .InstrAddr(addr_s), .Instr(instr_s),
        .InData(in_data), .InValid(in_valid), .InReady(ready_s),
        .Acc(acc_s), .OutStrobe(strobe_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Architectural model: index 0 = wrapping build, 1 = saturating build.
    int m_pc;
    int m_acc [2];
    int m_reg [2][NR];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int wrap(input int v);
        logic [DW-1:0] t;
        t = v[DW-1:0];
        return sx(t);
    endfunction

    function automatic int add_m(input int a, input int b, input int sat);
        int s;
        s = a + b;
        if (sat != 0) begin
            if (s > 127) s = 127;
            if (s < -128) s = -128;
        end
        return wrap(s);
    endfunction

    function automatic int mul_m(input int a, input int b);
        return wrap((a * b) >>> (DW - 1));
    endfunction

    function automatic logic [IW-1:0] enc(input int op, input int rd, input int imm);
        logic [2:0]    o;
        logic [RW-1:0] r;
        logic [DW-1:0] i;
        o = op[2:0];
        r = rd[RW-1:0];
        i = imm[DW-1:0];
        return {o, r, i};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    endtask

    task automatic model_reset();
        m_pc = 0;
        for (int s = 0; s < 2; s++) begin
            m_acc[s] = 0;
            for (int r = 0; r < NR; r++) m_reg[s][r] = 0;
        end
    endtask

    // Leaves the cores in FETCH of address 0, one edge before the first fetch edge.
    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_acc_w", sx(acc_w), 0);
        check("rst_acc_s", sx(acc_s), 0);
        check("rst_pc", int'(addr_w), 0);
        check("rst_ready", int'(ready_w | ready_s), 0);
        check("rst_strobe", int'(strobe_w | strobe_s), 0);
        rst = 1'b0;
    endtask

    // Runs one instruction starting in FETCH and returns in the next FETCH.
    task automatic run_instr(input int wait_cyc, input int in_val);
        logic [IW-1:0] w;
        int op, rd, imm, exp_strobe;
        w   = rom[m_pc];
        op  = int'(w[IW-1 -: 3]);
        rd  = int'(w[DW +: RW]);
        imm = sx(w[DW-1:0]);
        check("fetch_pc_w", int'(addr_w), m_pc);
        check("fetch_pc_s", int'(addr_s), m_pc);
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (op == 6) begin
            in_valid = 1'b0;
            for (int i = 0; i < wait_cyc; i++) begin
                check("in_wait_ready", int'(ready_w & ready_s), 1);
                check("in_wait_acc", sx(acc_w), m_acc[0]);
                check("in_wait_pc", int'(addr_w), m_pc);
                @(posedge clk); #1;
            end
            check("in_ready", int'(ready_w & ready_s), 1);
            in_data  = in_val[DW-1:0];
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_data  = DW'($urandom);
        end else begin
            check("exec_ready", int'(ready_w | ready_s), 0);
            @(posedge clk); #1;
        end
        for (int s = 0; s < 2; s++) begin
            case (op)
                1: m_acc[s] = imm;
                2: m_acc[s] = add_m(m_acc[s], imm, s);
                3: m_acc[s] = mul_m(m_acc[s], imm);
                4: m_acc[s] = add_m(m_acc[s], m_reg[s][rd], s);
                5: m_reg[s][rd] = m_acc[s];
                6: m_acc[s] = wrap(in_val);
                default: ;
            endcase
        end
        exp_strobe = (op >= 1 && op <= 4) || op == 6;
        check("next_acc_w", sx(acc_w), m_acc[0]);
        check("next_acc_s", sx(acc_s), m_acc[1]);
        check("next_strobe_w", int'(strobe_w), exp_strobe);
        check("next_strobe_s", int'(strobe_s), exp_strobe);
        check("next_ready", int'(ready_w | ready_s), 0);
        @(posedge clk); #1;
        m_pc = (op == 7) ? (imm & (DEPTH - 1)) : (m_pc + 1) % DEPTH;
        check("fetch_strobe", int'(strobe_w | strobe_s), 0);
    endtask

    initial begin
        clear_rom();

        // Basic LDI / ADDI timing
        rom[0] = enc(1, 0, 5);
        rom[1] = enc(2, 0, 3);
        do_reset();
        run_instr(0, 0);
        check("ldi5", sx(acc_w), 5);
        run_instr(0, 0);
        check("addi3", sx(acc_w), 8);

        // Wrap vs saturate on ADDI
        clear_rom();
        rom[0] = enc(1, 0, 120);
        rom[1] = enc(2, 0, 10);
        rom[2] = enc(1, 0, -120);
        rom[3] = enc(2, 0, -10);
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        check("pos_wrap", sx(acc_w), -126);
        check("pos_sat", sx(acc_s), 127);
        run_instr(0, 0);
        run_instr(0, 0);
        check("neg_wrap", sx(acc_w), 126);
        check("neg_sat", sx(acc_s), -128);

        // MULI fixed-point behaviour
        clear_rom();
        rom[0] = enc(1, 0, 64);
        rom[1] = enc(3, 0, 64);
        rom[2] = enc(1, 0, -128);
        rom[3] = enc(3, 0, -128);
        do_reset();
        run_instr(0, 0);
        run_instr(0, 0);
        check("mul_64", sx(acc_s), 32);
        run_instr(0, 0);
        run_instr(0, 0);
        check("mul_m128_w", sx(acc_w), -128);
        check("mul_m128_s", sx(acc_s), -128);

        // IN with a five-cycle stall
        clear_rom();
        rom[0] = enc(1, 0, 3);
        rom[1] = enc(6, 0, 0);
        do_reset();
        run_instr(0, 0);
        run_instr(5, -7);
        check("in_m7", sx(acc_w), -7);

        // STR / ADDR round trip
        clear_rom();
        rom[0] = enc(1, 0, 9);
        rom[1] = enc(5, 2, 0);
        rom[2] = enc(1, 0, 0);
        rom[3] = enc(4, 2, 0);
        do_reset();
        for (int i = 0; i < 4; i++) run_instr(0, 0);
        check("addr_r2_w", sx(acc_w), 9);
        check("addr_r2_s", sx(acc_s), 9);

        // JMP to the last address, then PC wraps to 0
        clear_rom();
        rom[0]  = enc(7, 0, 31);
        rom[31] = enc(0, 0, 0);
        do_reset();
        check("jmp_seq0", int'(addr_w), 0);
        run_instr(0, 0);
        check("jmp_seq31", int'(addr_w), 31);
        run_instr(0, 0);
        check("jmp_seq_wrap", int'(addr_w), 0);

        // Reset during an IN wait with InValid raised in the same cycle
        clear_rom();
        rom[0] = enc(6, 0, 0);
        rom[1] = enc(1, 0, 5);
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_ready_pre", int'(ready_w), 1);
        @(posedge clk); #1;
        in_data  = 8'hF9;
        in_valid = 1'b1;
        rst      = 1'b1;
        #1;
        check("abort_ready", int'(ready_w | ready_s), 0);
        check("abort_acc", sx(acc_w), 0);
        check("abort_pc", int'(addr_w), 0);
        @(posedge clk); #1;
        check("abort_acc_hold", sx(acc_w) | sx(acc_s), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        run_instr(1, 33);
        run_instr(0, 0);
        check("abort_restart", sx(acc_w), 5);

        // Random programs against the model
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < DEPTH; i++) rom[i] = IW'($urandom);
            do_reset();
            for (int n = 0; n < 120; n++) begin
                run_instr($urandom_range(0, 3), int'($urandom_range(0, 255)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
